// File: rtl/operand_loader.sv
// operand_loader: captures five 4-bit operands (A..E) from switch inputs X
// using a single debounced "enter" button, presenting them as registered
// slots with a valid flag for the downstream adder.
// Optional feature macro: OPLOAD_UNDO_EN (adds a debounced "back" button
// that steps the loader to the previous slot and zeroes it).

module opload_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] arm_cnt_q;
  logic             armed_q;

  // Two-flop synchronizer, level debouncer and press arming.
  // After reset a press is only honoured once the button has been seen low
  // long enough to rule out a press that was already held through reset
  // (the synchronizer reads 0 for two cycles after reset even when held).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
      arm_cnt_q  <= '0;
      armed_q    <= 1'b0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q != deb_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
      if (!armed_q) begin
        if (sync2_q) begin
          arm_cnt_q <= '0;
        end else if (arm_cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
          armed_q <= 1'b1;
        end else begin
          arm_cnt_q <= arm_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign press_o = deb_q & ~deb_prev_q & armed_q;

endmodule

module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] X,
  input  logic       PB,
  input  logic       PB_BACK,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [3:0] E,
  output logic [2:0] slot,
  output logic       load_strobe,
  output logic       ops_valid
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_C    = 3'd2,
    S_D    = 3'd3,
    S_E    = 3'd4,
    S_FULL = 3'd5
  } state_t;

  state_t     state_q;
  logic [3:0] a_q, b_q, c_q, d_q, e_q;
  logic       strobe_q, valid_q;
  logic       enter_press;

  opload_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (PB),
    .press_o (enter_press)
  );

`ifdef OPLOAD_UNDO_EN
  logic back_press;

  opload_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_back (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (PB_BACK),
    .press_o (back_press)
  );
`else
  logic unused_pb_back;
  assign unused_pb_back = PB_BACK;
`endif

  // Slot sequencer: enter writes X into the current slot and advances;
  // a press while full restarts at A. Back (if built) steps back one slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_A;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      c_q      <= 4'd0;
      d_q      <= 4'd0;
      e_q      <= 4'd0;
      strobe_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      strobe_q <= enter_press;
      if (enter_press) begin
        case (state_q)
          S_A:    begin a_q <= X; state_q <= S_B; end
          S_B:    begin b_q <= X; state_q <= S_C; end
          S_C:    begin c_q <= X; state_q <= S_D; end
          S_D:    begin d_q <= X; state_q <= S_E; end
          S_E:    begin e_q <= X; state_q <= S_FULL; valid_q <= 1'b1; end
          S_FULL: begin a_q <= X; state_q <= S_B; valid_q <= 1'b0; end
          default: state_q <= S_A;
        endcase
`ifdef OPLOAD_UNDO_EN
      end else if (back_press) begin
        case (state_q)
          S_B:    begin a_q <= 4'd0; state_q <= S_A; valid_q <= 1'b0; end
          S_C:    begin b_q <= 4'd0; state_q <= S_B; valid_q <= 1'b0; end
          S_D:    begin c_q <= 4'd0; state_q <= S_C; valid_q <= 1'b0; end
          S_E:    begin d_q <= 4'd0; state_q <= S_D; valid_q <= 1'b0; end
          S_FULL: begin e_q <= 4'd0; state_q <= S_E; valid_q <= 1'b0; end
          default: ;
        endcase
`endif
      end
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign C           = c_q;
  assign D           = d_q;
  assign E           = e_q;
  assign slot        = state_q;
  assign load_strobe = strobe_q;
  assign ops_valid   = valid_q;

endmodule
